// File: rtl/dac_xy_tx.sv
`timescale 1ns/1ps
// dac_xy_tx
//   Transmit side of the XY converter interface. Paired X/Y samples are
//   accepted on a valid/ready input into a small FIFO. One sample is emitted
//   to an external dual DAC per sample period. The DAC sample clock is
//   derived from clk.
//
// Optional build macro: DAC_XY_TX_BLANK_EN
//   When defined, adds a dac_blank output. On an underflow slot the buses
//   are driven to midscale and dac_blank is raised. When undefined, an
//   underflow slot holds the last bus value.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   reset      synchronous, active-high reset
//   s_x, s_y   X/Y sample input (DATA_BITS each)
//   s_valid    input sample valid
//   s_ready    FIFO can accept (depends only on registered occupancy)
//   dac_clk    registered DAC sample clock, CLK_DIV/2 low then CLK_DIV/2 high
//   dac_x_bus  registered X DAC data; changes only as dac_clk falls
//   dac_y_bus  registered Y DAC data; changes only as dac_clk falls
//   underflow  one-cycle pulse when a sample slot finds the FIFO empty
//   dac_blank  (DAC_XY_TX_BLANK_EN only) high while the buses carry blank data
module dac_xy_tx #(
  parameter int DATA_BITS  = 10,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] s_x,
  input  logic [DATA_BITS-1:0] s_y,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 dac_clk,
  output logic [DATA_BITS-1:0] dac_x_bus,
  output logic [DATA_BITS-1:0] dac_y_bus,
  output logic                 underflow
`ifdef DAC_XY_TX_BLANK_EN
  ,
  output logic                 dac_blank
`endif
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 * DATA_BITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // Divider
  logic [CNT_W-1:0] div_cnt_reg;
  logic             dac_clk_reg;
  logic             wrap;
  logic             rise;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  // Output registers
  logic [DATA_BITS-1:0] dac_x_reg;
  logic [DATA_BITS-1:0] dac_y_reg;
  logic                 underflow_reg;

  assign wrap  = (div_cnt_reg == CNT_LAST);
  assign rise  = (div_cnt_reg == CNT_HALF);
  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  // Ready comes from registered occupancy only, so a full FIFO stays
  // not-ready even on the cycle it pops.
  assign s_ready = ~full;
  assign push    = s_valid & ~full;
  // Pop decision uses the occupancy before this edge: a push landing on the
  // same wrap edge into an empty FIFO waits for the next slot.
  assign pop     = wrap & ~empty;
  assign head    = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      dac_clk_reg <= 1'b0;
    end else begin
      div_cnt_reg <= wrap ? '0 : div_cnt_reg + 1'b1;
      if (wrap) begin
        dac_clk_reg <= 1'b0;
      end else if (rise) begin
        dac_clk_reg <= 1'b1;
      end
    end
  end

  // Storage array has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_x, s_y};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

`ifdef DAC_XY_TX_BLANK_EN
  localparam logic [DATA_BITS-1:0] MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};
  logic dac_blank_reg;
  assign dac_blank = dac_blank_reg;
`endif

  // Buses load only on the wrap edge, i.e. together with dac_clk falling.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_x_reg     <= '0;
      dac_y_reg     <= '0;
      underflow_reg <= 1'b0;
`ifdef DAC_XY_TX_BLANK_EN
      dac_blank_reg <= 1'b1;
`endif
    end else begin
      underflow_reg <= wrap & empty;
      if (pop) begin
        dac_x_reg <= head[ENT_W-1:DATA_BITS];
        dac_y_reg <= head[DATA_BITS-1:0];
`ifdef DAC_XY_TX_BLANK_EN
        dac_blank_reg <= 1'b0;
`endif
      end else if (wrap) begin
`ifdef DAC_XY_TX_BLANK_EN
        dac_x_reg     <= MIDSCALE;
        dac_y_reg     <= MIDSCALE;
        dac_blank_reg <= 1'b1;
`endif
      end
    end
  end

  assign dac_clk   = dac_clk_reg;
  assign dac_x_bus = dac_x_reg;
  assign dac_y_bus = dac_y_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_dac_xy_tx.sv
`timescale 1ns/1ps
// Testbench for dac_xy_tx (CLK_DIV=4, FIFO_DEPTH=4, DATA_BITS=10).
// Stimulus pushes the expected outcome of each sample slot into a
// scoreboard queue; a monitor on the falling clock edge checks dac_clk,
// underflow and the buses every cycle and pops an entry at each slot.
module tb_dac_xy_tx;

  localparam int DB = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] s_x;
  logic [DB-1:0] s_y;
  logic          s_valid;
  logic          s_ready;
  logic          dac_clk;
  logic [DB-1:0] dac_x_bus;
  logic [DB-1:0] dac_y_bus;
  logic          underflow;
`ifdef DAC_XY_TX_BLANK_EN
  logic          dac_blank;
`endif

  dac_xy_tx #(.DATA_BITS(DB), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_x       (s_x),
    .s_y       (s_y),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .dac_clk   (dac_clk),
    .dac_x_bus (dac_x_bus),
    .dac_y_bus (dac_y_bus),
    .underflow (underflow)
`ifdef DAC_XY_TX_BLANK_EN
    ,
    .dac_blank (dac_blank)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        uf;
    logic [DB-1:0] x;
    logic [DB-1:0] y;
    logic        blank;
  } slot_t;

  slot_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc;
  bit    mon_en = 1'b0;

  // Cycles since reset was last released; the slot edges are multiples of 4.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_data(input int k, input logic [DB-1:0] x, input logic [DB-1:0] y);
    slot_t e;
    e.k = k; e.uf = 1'b0; e.x = x; e.y = y; e.blank = 1'b0;
    sb.push_back(e);
  endtask

  // Underflow slot: hold (hx,hy) in the default build, midscale when blanking.
  task automatic exp_uf(input int k, input logic [DB-1:0] hx, input logic [DB-1:0] hy);
    slot_t e;
    e.k = k; e.uf = 1'b1; e.blank = 1'b1;
`ifdef DAC_XY_TX_BLANK_EN
    e.x = 10'h200; e.y = 10'h200;
`else
    e.x = hx; e.y = hy;
`endif
    sb.push_back(e);
  endtask

  // Monitor
  logic [DB-1:0] last_x, last_y;
  logic          last_blank;
  slot_t         me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == 0) begin
        last_x = '0; last_y = '0; last_blank = 1'b1;
      end
      chk("dac_clk", 32'(dac_clk), 32'((cyc % 4) >= 2));
      if (cyc > 0 && (cyc % 4) == 0) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_empty at cyc %0d: got slot with no expectation queued", cyc);
        end else begin
          me = sb.pop_front();
          chk("slot_k", 32'(cyc), 32'(me.k));
          chk("slot_underflow", 32'(underflow), 32'(me.uf));
          chk("slot_x", 32'(dac_x_bus), 32'(me.x));
          chk("slot_y", 32'(dac_y_bus), 32'(me.y));
`ifdef DAC_XY_TX_BLANK_EN
          chk("slot_blank", 32'(dac_blank), 32'(me.blank));
          last_blank = me.blank;
`endif
          last_x = me.x; last_y = me.y;
        end
      end else begin
        chk("idle_underflow", 32'(underflow), 32'd0);
        chk("hold_x", 32'(dac_x_bus), 32'(last_x));
        chk("hold_y", 32'(dac_y_bus), 32'(last_y));
`ifdef DAC_XY_TX_BLANK_EN
        chk("hold_blank", 32'(dac_blank), 32'(last_blank));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_k(input int n);
    int g = 0;
    while (cyc != n && g < 500) begin
      tick();
      g++;
    end
    chk("wait_k", 32'(cyc), 32'(n));
  endtask

  logic [DB-1:0] sx [6];
  logic [DB-1:0] sy [6];
  bit            rdy;
  int            idx;
  bit            exp_rdy;

  initial begin
    sx[0] = 10'h011; sy[0] = 10'h3EE;
    sx[1] = 10'h022; sy[1] = 10'h3DD;
    sx[2] = 10'h033; sy[2] = 10'h3CC;
    sx[3] = 10'h044; sy[3] = 10'h3BB;
    sx[4] = 10'h055; sy[4] = 10'h3AA;
    sx[5] = 10'h066; sy[5] = 10'h399;

    reset = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0;
    tick(); tick();
    mon_en = 1'b1;
    reset  = 1'b0;
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // Idle slots, then one sample pushed while div_cnt=1 (edge 10).
    exp_uf(4, 10'h000, 10'h000);
    exp_uf(8, 10'h000, 10'h000);
    exp_data(12, 10'h155, 10'h2AA);
    wait_k(9);
    s_valid = 1'b1; s_x = 10'h155; s_y = 10'h2AA;
    chk("ready_single", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;

    // Back-pressure run; the first push lands on wrap edge 16 with an empty
    // FIFO, so slot 16 underflows and that sample shows at slot 20.
    exp_uf(16, 10'h155, 10'h2AA);
    for (int i = 0; i < 6; i++) exp_data(20 + 4 * i, sx[i], sy[i]);
    exp_uf(44, sx[5], sy[5]);
    wait_k(15);
    idx = 0;
    s_valid = 1'b1;
    for (int g = 0; g < 40 && idx < 6; g++) begin
      s_x = sx[idx]; s_y = sy[idx];
      exp_rdy = (cyc <= 18) || (cyc == 20) || (cyc == 24);
      chk("ready_backpressure", 32'(s_ready), 32'(exp_rdy));
      rdy = s_ready;
      tick();
      if (rdy) idx++;
    end
    s_valid = 1'b0;
    chk("accepted_count", 32'(idx), 32'd6);

    // Fill three entries, then reset mid-period; none may ever appear.
    wait_k(43);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_x = 10'(10'h101 + 2 * i); s_y = 10'(10'h202 + 2 * i);
      chk("ready_prefill", 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_x", 32'(dac_x_bus), 32'd0);
    chk("reset_y", 32'(dac_y_bus), 32'd0);
    chk("reset_clk", 32'(dac_clk), 32'd0);
    chk("reset_ready", 32'(s_ready), 32'd1);
    chk("reset_sb_drained", 32'(sb.size()), 32'd0);

    exp_uf(4, 10'h000, 10'h000);
    exp_uf(8, 10'h000, 10'h000);
    exp_data(12, 10'h3FF, 10'h001);
    exp_uf(16, 10'h3FF, 10'h001);
    wait_k(9);
    s_valid = 1'b1; s_x = 10'h3FF; s_y = 10'h001;
    chk("ready_full_scale", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    wait_k(18);
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
